sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/arb_tag_fifo.sv | 45 ++++
 rtl/sdram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and master IDs for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } arb_state_t;

  localparam logic M_VGA = 1'b0;
  localparam logic M_DNN = 1'b1;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit issuer-tag FIFO for outstanding reads; push is honoured when
// full only if a pop happens in the same cycle.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [DEPTH-1:0] mem;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + {{PW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller (VGA = m0, DNN = m1).
// Define SDRAM_ARB_RR_EN for round-robin; default is m0 priority with a starvation limiter.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned AW           = 25,
  parameter int unsigned DW           = 16,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_readdatavalid,
  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic            s_waitrequest,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_readdatavalid,
  output logic            err_orphan
);

  arb_state_t state;

  logic req0;
  logic req1;
  logic acc0;
  logic acc1;
  logic fifo_full;
  logic fifo_empty;
  logic tag_head;
  logic tag_push;
  logic tag_pop;
  logic rd_blocked;
  logic win1_idle;
  logic switch0;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // A same-cycle return frees a slot, so a full FIFO only blocks when nothing pops.
  assign tag_pop    = s_readdatavalid & ~fifo_empty;
  assign rd_blocked = fifo_full & ~tag_pop;

  assign acc0 = (state == GNT0) && req0 && !s_waitrequest && !(m0_read && rd_blocked);
  assign acc1 = (state == GNT1) && req1 && !s_waitrequest && !(m1_read && rd_blocked);

  assign tag_push = (acc0 & m0_read) | (acc1 & m1_read);

  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    unique case (state)
      GNT0: begin
        s_address    = m0_address;
        s_read       = m0_read & ~rd_blocked;
        s_write      = m0_write;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
      end
      GNT1: begin
        s_address    = m1_address;
        s_read       = m1_read & ~rd_blocked;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest = (state == GNT0) ? (s_waitrequest | (m0_read & rd_blocked)) : 1'b1;
  assign m1_waitrequest = (state == GNT1) ? (s_waitrequest | (m1_read & rd_blocked)) : 1'b1;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = tag_pop & (tag_head == M_VGA);
  assign m1_readdatavalid = tag_pop & (tag_head == M_DNN);

`ifdef SDRAM_ARB_RR_EN
  logic last_m1;

  assign win1_idle = ~last_m1;
  assign switch0   = 1'b1;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      last_m1 <= 1'b1;
    end else if (acc0) begin
      last_m1 <= 1'b0;
    end else if (acc1) begin
      last_m1 <= 1'b1;
    end
  end
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve;
  logic [SW-1:0] starve_inc;

  assign starve_inc = (starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1);
  assign win1_idle  = (starve == SW'(STARVE_LIMIT));
  // Decide on the post-accept count so exactly STARVE_LIMIT m0 accepts precede the m1 turn.
  assign switch0    = (starve_inc == SW'(STARVE_LIMIT));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      starve <= '0;
    end else if (acc1 || !req1) begin
      starve <= '0;
    end else if (acc0) begin
      starve <= starve_inc;
    end
  end
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      err_orphan <= 1'b0;
    end else begin
      if (s_readdatavalid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (req0 && req1) begin
            state <= win1_idle ? GNT1 : GNT0;
          end else if (req0) begin
            state <= GNT0;
          end else if (req1) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (!req0) begin
            state <= req1 ? GNT1 : IDLE;
          end else if (acc0 && req1 && switch0) begin
            state <= GNT1;
          end
        end
        GNT1: begin
          if (!req1) begin
            state <= req0 ? GNT0 : IDLE;
          end else if (acc1 && req0) begin
            state <= GNT0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_tag_fifo #(
    .DEPTH(MAX_PENDING)
  ) u_tag_fifo (
    .clk   (clk_clk),
    .reset (reset_reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   ((state == GNT1) ? M_DNN : M_VGA),
    .dout  (tag_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter in its default (fixed-priority) build.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;

  logic            clk_clk = 1'b0;
  logic            reset_reset;
  logic [AW-1:0]   m0_address, m1_address;
  logic            m0_read, m1_read, m0_write, m1_write;
  logic [DW-1:0]   m0_writedata, m1_writedata;
  logic [DW/8-1:0] m0_byteenable, m1_byteenable;
  logic            m0_waitrequest, m1_waitrequest;
  logic [DW-1:0]   m0_readdata, m1_readdata;
  logic            m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0]   s_address;
  logic            s_read, s_write;
  logic [DW-1:0]   s_writedata;
  logic [DW/8-1:0] s_byteenable;
  logic            s_waitrequest;
  logic [DW-1:0]   s_readdata = '0;
  logic            s_readdatavalid = 1'b0;
  logic            err_orphan;

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_PENDING(8), .STARVE_LIMIT(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave model: returns address[15:0] as data, lat cycles after accept.
  int          cyc = 0;
  int          lat = 2;
  bit          hold = 1'b0;
  int          rel_req = 0, rel_done = 0;
  int          stray_req = 0, stray_done = 0;
  int          flush_req = 0, flush_done = 0;
  int          pend_due[$];
  logic [15:0] pend_data[$];

  always begin
    @(negedge clk_clk);
    if (!reset_reset && s_read && !s_waitrequest) begin
      pend_due.push_back(cyc + lat);
      pend_data.push_back(s_address[15:0]);
    end
    @(posedge clk_clk);
    cyc++;
    #2;
    s_readdatavalid = 1'b0;
    if (flush_done < flush_req) begin
      pend_due.delete();
      pend_data.delete();
      flush_done++;
    end
    if (stray_done < stray_req) begin
      s_readdatavalid = 1'b1;
      s_readdata      = 16'hDEAD;
      stray_done++;
    end else if (pend_due.size() > 0 && (rel_done < rel_req || (!hold && pend_due[0] <= cyc))) begin
      s_readdatavalid = 1'b1;
      s_readdata      = pend_data.pop_front();
      void'(pend_due.pop_front());
      if (rel_done < rel_req) rel_done++;
    end
  end

  int          acc_log[$];
  int          rdv_id[$];
  logic [15:0] rdv_data[$];

  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if ((m0_read || m0_write) && !m0_waitrequest) acc_log.push_back(0);
      if ((m1_read || m1_write) && !m1_waitrequest) acc_log.push_back(1);
      if (m0_readdatavalid) begin rdv_id.push_back(0); rdv_data.push_back(m0_readdata); end
      if (m1_readdatavalid) begin rdv_id.push_back(1); rdv_data.push_back(m1_readdata); end
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic idle_m(input int m);
    if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else        begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  // Present one transfer and hold it until accepted (bounded wait).
  task automatic master_xfer(input int m, input logic wr, input logic [AW-1:0] a);
    bit ok = 1'b0;
    if (m == 0) begin
      m0_read = !wr; m0_write = wr; m0_address = a; m0_writedata = a[15:0] ^ 16'hFFFF;
    end else begin
      m1_read = !wr; m1_write = wr; m1_address = a; m1_writedata = a[15:0] ^ 16'hFFFF;
    end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_clk);
      ok = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
      tick();
    end
    if (!ok) check($sformatf("xfer_timeout_m%0d", m), 32'd0, 32'd1);
  endtask

  int exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_id[4]   = '{0, 1, 1, 0};
  int base, abase;

  initial begin
    reset_reset = 1'b1;
    m0_address = '0; m1_address = '0;
    m0_read = 1'b0; m1_read = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
    m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '1; m1_byteenable = '1;
    s_waitrequest = 1'b0;
    wait_n(3);
    reset_reset = 1'b0;

    @(negedge clk_clk);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_m0_rdv", m0_readdatavalid, 0);
    check("rst_m1_rdv", m1_readdatavalid, 0);
    check("rst_err_orphan", err_orphan, 0);
    tick();

    // m0 only: four back-to-back reads, returns two cycles after accept
    base = rdv_id.size();
    for (int i = 0; i < 4; i++) master_xfer(0, 1'b0, AW'(32'h10 + i));
    idle_m(0);
    wait_n(8);
    check("m0only_count", rdv_id.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("m0only_id%0d", i), rdv_id[base + i], 0);
      check($sformatf("m0only_data%0d", i), rdv_data[base + i], 32'h10 + i);
    end

    // Both masters reading continuously: starvation limiter pattern
    base  = rdv_id.size();
    abase = acc_log.size();
    m0_address = AW'(32'h20); m1_address = AW'(32'h30);
    m0_read = 1'b1; m1_read = 1'b1;
    wait_n(14);
    idle_m(0); idle_m(1);
    wait_n(8);
    check("arb_acc_enough", acc_log.size() >= abase + 10, 1);
    for (int i = 0; i < 10; i++)
      check($sformatf("arb_pat%0d", i), acc_log[abase + i], exp_pat[i]);
    check("arb_rdv_total", rdv_id.size() - base, acc_log.size() - abase);

    // m1 write held under slave waitrequest while m0 requests
    s_waitrequest = 1'b1;
    m1_write = 1'b1; m1_address = AW'(32'h1AB); m1_writedata = 16'hBEEF;
    tick();
    m0_read = 1'b1; m0_address = AW'(32'h77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      check($sformatf("hold_s_write%0d", i), s_write, 1);
      check($sformatf("hold_s_addr%0d", i), s_address, 32'h1AB);
      check($sformatf("hold_m0_wait%0d", i), m0_waitrequest, 1);
      check($sformatf("hold_m1_wait%0d", i), m1_waitrequest, 1);
      tick();
    end
    s_waitrequest = 1'b0;
    @(negedge clk_clk);
    check("hold_m1_accept", m1_waitrequest, 0);
    check("hold_s_wdata", s_writedata, 32'hBEEF);
    tick();
    m1_write = 1'b0;
    @(negedge clk_clk);
    check("hold_switch_s_read", s_read, 1);
    check("hold_switch_s_addr", s_address, 32'h77);
    check("hold_switch_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 1'b0;
    wait_n(8);

    // Interleaved reads 0,1,1,0 with three-cycle returns
    lat  = 3;
    base = rdv_id.size();
    master_xfer(0, 1'b0, AW'(32'h40));
    idle_m(0);
    master_xfer(1, 1'b0, AW'(32'h41));
    master_xfer(1, 1'b0, AW'(32'h42));
    idle_m(1);
    master_xfer(0, 1'b0, AW'(32'h43));
    idle_m(0);
    wait_n(10);
    check("inter_count", rdv_id.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("inter_id%0d", i), rdv_id[base + i], exp_id[i]);
      check($sformatf("inter_data%0d", i), rdv_data[base + i], 32'h40 + i);
    end

    // Slave withholds data: 8 reads fill the tag FIFO, 9th stalls until one return
    hold  = 1'b1;
    base  = rdv_id.size();
    abase = acc_log.size();
    for (int i = 0; i < 8; i++) master_xfer(0, 1'b0, AW'(32'h80 + i));
    check("full_acc_count", acc_log.size() - abase, 8);
    m0_address = AW'(32'h88); m0_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      check($sformatf("full_m0_wait%0d", i), m0_waitrequest, 1);
      check($sformatf("full_s_read%0d", i), s_read, 0);
      tick();
    end
    rel_req++;
    @(negedge clk_clk);
    check("unblk_rdv", m0_readdatavalid, 1);
    check("unblk_data", m0_readdata, 32'h80);
    check("unblk_m0_wait", m0_waitrequest, 0);
    check("unblk_s_read", s_read, 1);
    tick();
    m0_read = 1'b0;
    hold = 1'b0;
    wait_n(16);
    check("full_rdv_total", rdv_id.size() - base, 9);

    // Reset with three reads pending, then a stray return
    hold = 1'b1;
    master_xfer(0, 1'b0, AW'(32'h90));
    idle_m(0);
    master_xfer(1, 1'b0, AW'(32'h91));
    idle_m(1);
    master_xfer(0, 1'b0, AW'(32'h92));
    idle_m(0);
    reset_reset = 1'b1;
    flush_req++;
    wait_n(2);
    reset_reset = 1'b0;
    hold = 1'b0;
    @(negedge clk_clk);
    check("rst2_err_orphan", err_orphan, 0);
    check("rst2_m0_wait", m0_waitrequest, 1);
    check("rst2_m1_wait", m1_waitrequest, 1);
    check("rst2_s_read", s_read, 0);
    tick();
    stray_req++;
    @(negedge clk_clk);
    check("stray_m0_rdv", m0_readdatavalid, 0);
    check("stray_m1_rdv", m1_readdatavalid, 0);
    tick();
    @(negedge clk_clk);
    check("stray_err_orphan", err_orphan, 1);
    wait_n(3);
    @(negedge clk_clk);
    check("stray_err_sticky", err_orphan, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
